// File: rtl/ula_scandoubler_if.sv
`default_nettype none
// ============================================================================
//  Module      : ula_scandoubler_if
//  Description : Video bundle between the ULA pixel source, the scandoubler
//                and the DAC / VGA sync pins.
//  Revision    : 1.0  initial release
// ============================================================================
interface ula_scandoubler_if #(
    parameter int DW = 8
);
    logic          pix_ce;
    logic [DW-1:0] din;
    logic          hsync_n_in;
    logic          vsync_n_in;
    logic          enable;
    logic [DW-1:0] dout;
    logic          hsync_n_out;
    logic          vsync_n_out;

    // master = pixel source side, slave = scandoubler side
    modport master (
        output pix_ce, din, hsync_n_in, vsync_n_in, enable,
        input  dout, hsync_n_out, vsync_n_out
    );

    modport slave (
        input  pix_ce, din, hsync_n_in, vsync_n_in, enable,
        output dout, hsync_n_out, vsync_n_out
    );
endinterface
`default_nettype wire

// File: rtl/ula_scandoubler.sv
`default_nettype none
// ============================================================================
//  Module      : ula_scandoubler
//  Description : Buffers each 15.6 kHz ULA line and replays it twice at the
//                full clk14 rate for 31.2 kHz VGA, with a 15 kHz bypass path.
//  Revision    : 1.0  initial release
// ============================================================================
module ula_scandoubler #(
    parameter int DW       = 8,
    parameter int LINE_LEN = 448,
    parameter int AW       = 9,
    parameter int HS_LEN   = 54
) (
    input  logic             clk14,
    input  logic             reset_n,
    ula_scandoubler_if.slave vid
);
    localparam logic [AW-1:0] c_LAST_X = AW'(LINE_LEN - 1);
    localparam logic [AW-1:0] c_HS_LEN = AW'(HS_LEN);
    localparam logic [AW-1:0] c_ONE    = AW'(1);

    // two line banks addressed as {bank, x}
    logic [DW-1:0] r_mem [2**(AW+1)];

    logic          r_hs_prev;
    logic          w_hs_fall;
    logic [AW-1:0] r_wr_x;
    logic          r_wr_bank;
    logic          w_wr_en;
    logic [AW:0]   w_wr_addr;

    logic [AW-1:0] r_rd_x;
    logic          r_rd_bank;
    logic          r_line_valid;

    logic [DW-1:0] r_s1_data;
    logic          r_s1_valid;
    logic          r_s1_hsync;
    logic          r_s1_vsync;

    logic [DW-1:0] r_dout;
    logic          r_hsync_out;
    logic          r_vsync_out;

    assign w_hs_fall = r_hs_prev & ~vid.hsync_n_in;

    // A pixel arriving with the hsync edge already belongs to the new bank.
    always_comb begin
        w_wr_en   = vid.pix_ce & reset_n;
        w_wr_addr = {r_wr_bank, r_wr_x};
        if (w_hs_fall) begin
            w_wr_addr = {~r_wr_bank, {AW{1'b0}}};
        end
    end

    always_ff @(posedge clk14) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= vid.din;
        end
        r_s1_data <= r_mem[{r_rd_bank, r_rd_x}];
    end

    always_ff @(posedge clk14) begin
        if (!reset_n) begin
            r_hs_prev <= 1'b1;
            r_wr_x    <= '0;
            r_wr_bank <= 1'b0;
        end else begin
            r_hs_prev <= vid.hsync_n_in;
            if (w_hs_fall) begin
                r_wr_bank <= ~r_wr_bank;
                r_wr_x    <= {{(AW-1){1'b0}}, vid.pix_ce};
            end else if (vid.pix_ce && (r_wr_x != c_LAST_X)) begin
                r_wr_x <= r_wr_x + c_ONE;
            end
        end
    end

    // Reader free-runs and replays the same bank until the next hsync edge.
    always_ff @(posedge clk14) begin
        if (!reset_n) begin
            r_rd_x       <= '0;
            r_rd_bank    <= 1'b0;
            r_line_valid <= 1'b0;
        end else if (w_hs_fall) begin
            r_rd_x       <= '0;
            r_rd_bank    <= r_wr_bank;
            r_line_valid <= 1'b1;
        end else if (r_rd_x == c_LAST_X) begin
            r_rd_x <= '0;
        end else begin
            r_rd_x <= r_rd_x + c_ONE;
        end
    end

    always_ff @(posedge clk14) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_hsync <= 1'b1;
            r_s1_vsync <= 1'b1;
        end else begin
            r_s1_valid <= r_line_valid;
            r_s1_hsync <= (r_rd_x >= c_HS_LEN);
            if (r_rd_x == '0) begin
                r_s1_vsync <= vid.vsync_n_in;
            end
        end
    end

    // Bypass taps the raw inputs; the doubled path keeps running underneath.
    always_ff @(posedge clk14) begin
        if (!reset_n) begin
            r_dout      <= '0;
            r_hsync_out <= 1'b1;
            r_vsync_out <= 1'b1;
        end else if (vid.enable) begin
            r_dout      <= r_s1_valid ? r_s1_data : '0;
            r_hsync_out <= r_s1_hsync;
            r_vsync_out <= r_s1_vsync;
        end else begin
            if (vid.pix_ce) begin
                r_dout <= vid.din;
            end
            r_hsync_out <= vid.hsync_n_in;
            r_vsync_out <= vid.vsync_n_in;
        end
    end

    assign vid.dout        = r_dout;
    assign vid.hsync_n_out = r_hsync_out;
    assign vid.vsync_n_out = r_vsync_out;
endmodule
`default_nettype wire

// File: doc/ula_scandoubler.md
Name: ula_scandoubler

Overview:
- Downstream of the ULA video output.
- Converts the ULA's 15.6 kHz PAL-timed pixel stream into a 31.2 kHz VGA-rate stream by buffering each input line and replaying it twice at double pixel rate.
- Input pixel data is either the 8-bit ULA+ RGB value or {i,g,r,b} zero-extended; selection is external to this block.
- Outputs feed the RGB DAC and VGA connector sync pins.

Parameters:
DW, 8, pixel data width.
LINE_LEN, 448, input pixels per ULA line; also output clocks per VGA line.
AW, 9, line-buffer address width; must satisfy 2^AW >= LINE_LEN.
HS_LEN, 54, VGA hsync pulse width in clk14 cycles.

Ports:
clk14  input  1  14 MHz master clock; sole clock of the block.
reset_n  input  1  synchronous, active-low reset.
pix_ce  input  1  pixel strobe: 1 for one clk14 cycle per ULA pixel (7 MHz rate).
din  input  DW  pixel from the ULA, sampled when pix_ce=1.
hsync_n_in  input  1  ULA hsync, active low.
vsync_n_in  input  1  ULA vsync, active low.
enable  input  1  1 = scandouble; 0 = bypass (15 kHz passthrough).
dout  output  DW  pixel to the DAC.
hsync_n_out  output  1  output hsync, active low.
vsync_n_out  output  1  output vsync, active low.

Behaviour:
- Reset (reset_n=0 at a clk14 rising edge):
  - Outputs: dout=0, hsync_n_out=1, vsync_n_out=1.
  - Internal state: wr_x=0, rd_x=0, wr_bank=0, rd_pass=0, line_valid=0, hs_prev=1.
  - Line-buffer contents are not cleared.
- Line buffer: 2 banks x LINE_LEN x DW, one write port and one synchronous read port (1-cycle read latency).
- Edge detect: hs_prev <= hsync_n_in every clk14; hs_fall = hs_prev & !hsync_n_in.
- Write side:
  - If pix_ce and not hs_fall: write din at [wr_bank][wr_x]. wr_x increments and saturates at LINE_LEN-1; overflow pixels overwrite the last entry and never wrap into address 0.
  - On hs_fall: wr_bank toggles, and the read side loads rd_bank = old wr_bank, rd_x=0, rd_pass=0, line_valid=1.
  - If pix_ce coincides with hs_fall, din is written to address 0 of the new bank and wr_x <= 1; otherwise wr_x <= 0.
- Read side:
  - rd_x increments every clk14.
  - At rd_x==LINE_LEN-1: rd_x <= 0 and rd_pass toggles.
  - If no hs_fall arrives after pass 1, reading free-runs and repeats the same bank, so output timing never stalls.
  - hs_fall always overrides the free-run restart, including mid-line.
- Output timing (enable=1):
  - Stage 0: rd_x and derived hsync_raw = (rd_x < HS_LEN) ? 0 : 1.
  - Stage 1: RAM data and hsync_raw delayed one cycle.
  - Stage 2: registered outputs.
  - dout and hsync_n_out therefore have 2 clk14 cycles of latency from rd_x and stay mutually aligned.
  - dout = 0 while line_valid=0.
  - vsync_n_out <= vsync_n_in, sampled only in the cycle where stage-0 rd_x==0. Vsync changes only on output line boundaries, with the same 2-cycle pipeline.
- Bypass (enable=0):
  - dout <= din on pix_ce (held otherwise); hsync_n_out <= hsync_n_in; vsync_n_out <= vsync_n_in.
  - All bypass outputs are 1-cycle registered.
  - Write side keeps running, so switching back to enable=1 is glitch-free at the next hs_fall.
- enable changes take effect on the next clk14 edge. Stale pipeline contents are not flushed.
- Blanking is not generated here; the ULA already drives 0 during blanking and that is replayed.
- Reset mid-line: outputs return to reset values on the next edge; the first line after reset is dark (line_valid=0) until hs_fall.

Test Plan:
- Reset, then 2 full lines of pix_ce every other cycle with din=wr_x[7:0] and an hs_fall every 896 clk14 -> second output line pair: dout at stage-2 cycle k equals k mod 256 for k=0..447, repeated twice; hsync_n_out low for exactly 54 cycles starting at each rd_x=0 (+2 latency).
- No hsync after the first line -> rd_x wraps every 448 clk14, the same bank is replayed indefinitely, and the wr_x saturates at 447 with buffer entry 447 holding the latest din.
- hs_fall coincident with pix_ce and din=8'hA5 -> new bank address 0 = 8'hA5, wr_x=1, old bank is replayed from rd_x=0.
- vsync_n_in falls at rd_x=200 -> vsync_n_out falls exactly 2 cycles after the next rd_x==0, not before.
- enable=0 with din=8'h3C on pix_ce and hsync_n_in toggling -> dout=8'h3C and hsync_n_out = hsync_n_in, both one cycle late; set enable=1 -> doubled output resumes with correct phase after the next hs_fall.
- Assert reset_n=0 mid-line for 1 cycle -> next cycle dout=0, hsync_n_out=1, vsync_n_out=1; dout stays 0 until the first hs_fall after release.
